// File: rtl/demultiplexer_1_to_4_reg_if.sv
// Handshake bundle between one producer and four consumer lanes of the registered 1-to-4 demux.
// master = producer/consumer side (testbench or surrounding logic), slave = the demux itself.
interface demultiplexer_1_to_4_reg_if #(
    parameter int unsigned NBits = 32
);
    logic [1:0]       Selector_i;
    logic [NBits-1:0] Demux_Data_i;
    logic             Demux_Valid_i;
    logic             Demux_Ready_o;
    logic [NBits-1:0] Demux_Data_0_o;
    logic [NBits-1:0] Demux_Data_1_o;
    logic [NBits-1:0] Demux_Data_2_o;
    logic [NBits-1:0] Demux_Data_3_o;
    logic [3:0]       Demux_Valid_o;
    logic [3:0]       Demux_Ready_i;

    modport master (
        output Selector_i,
        output Demux_Data_i,
        output Demux_Valid_i,
        input  Demux_Ready_o,
        input  Demux_Data_0_o,
        input  Demux_Data_1_o,
        input  Demux_Data_2_o,
        input  Demux_Data_3_o,
        input  Demux_Valid_o,
        output Demux_Ready_i
    );

    modport slave (
        input  Selector_i,
        input  Demux_Data_i,
        input  Demux_Valid_i,
        output Demux_Ready_o,
        output Demux_Data_0_o,
        output Demux_Data_1_o,
        output Demux_Data_2_o,
        output Demux_Data_3_o,
        output Demux_Valid_o,
        input  Demux_Ready_i
    );
endinterface

// File: rtl/demultiplexer_1_to_4_reg.sv
// Registered 1-to-4 demux with a 1-entry holding register per lane and valid/ready on every side.
// Define DEMUX_COUNT_EN to add per-lane transfer counters on Xfer_Count_o.
module demultiplexer_1_to_4_reg #(
    parameter int unsigned NBits = 32
`ifdef DEMUX_COUNT_EN
    ,
    parameter int unsigned CNT_BITS = 16
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    demultiplexer_1_to_4_reg_if.slave   bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [4*CNT_BITS-1:0]       Xfer_Count_o
`endif
);

    logic [3:0]       valid_q, valid_d;
    logic [NBits-1:0] data_q [4];
    logic [NBits-1:0] data_d [4];
    logic [3:0]       consume;
    logic [3:0]       load;
    logic             ready;
    logic             accept;

    // Ready looks only at the selected lane and its consumer, never at Demux_Valid_i.
    always_comb begin
        ready   = 1'b0;
        accept  = 1'b0;
        load    = 4'b0000;
        consume = valid_q & bus.Demux_Ready_i;
        if (!reset) begin
            ready = ~valid_q[bus.Selector_i] | bus.Demux_Ready_i[bus.Selector_i];
        end
        accept = bus.Demux_Valid_i & ready;
        if (accept) begin
            load = 4'b0001 << bus.Selector_i;
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < 4; k++) begin
            data_d[k]  = data_q[k];
            valid_d[k] = load[k] | (valid_q[k] & ~consume[k]);
            if (load[k]) begin
                data_d[k] = bus.Demux_Data_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign bus.Demux_Ready_o  = ready;
    assign bus.Demux_Valid_o  = valid_q;
    assign bus.Demux_Data_0_o = data_q[0];
    assign bus.Demux_Data_1_o = data_q[1];
    assign bus.Demux_Data_2_o = data_q[2];
    assign bus.Demux_Data_3_o = data_q[3];

`ifdef DEMUX_COUNT_EN
    logic [CNT_BITS-1:0] cnt_q [4];
    logic [CNT_BITS-1:0] cnt_d [4];

    // Counters wrap naturally at 2^CNT_BITS.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
            if (consume[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt_out
        assign Xfer_Count_o[g*CNT_BITS +: CNT_BITS] = cnt_q[g];
    end
`endif

endmodule
